// File: rtl/sync_alu_pipe.sv
// Two-stage registered 8-op ALU with valid/ready on both sides.
// Optional build macro SYNC_ALU_SAT_EN: add/sub saturate instead of wrapping.
module sync_alu_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             b_out,
    output logic [1:0]       compare_out
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned W1  = WIDTH + 1;

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_GT   = 3'b011,
        OP_LT   = 3'b100,
        OP_EQ   = 3'b101,
        OP_SHR  = 3'b110,
        OP_SHL  = 3'b111
    } op_e;

    typedef struct packed {
        op_e              op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             c_in;
        logic             b_in;
    } s1_t;

    logic             r_s1_valid;
    s1_t              r_s1;
    logic             w_adv2;
    logic [W1-1:0]    w_sum;
    logic [W1-1:0]    w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_b;
    logic             w_cmp;

    // S2 may load whenever it is empty or its beat is leaving this cycle
    assign w_adv2   = !out_valid || out_ready;
    assign in_ready = !r_s1_valid || w_adv2;

    // Operand stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1.op   <= op_e'(op);
                r_s1.a    <= a;
                r_s1.b    <= b;
                r_s1.c_in <= c_in;
                r_s1.b_in <= b_in;
            end
        end
    end

    // Datapath between S1 and S2; flags not produced by an op stay 0
    always_comb begin
        w_res   = '0;
        w_c     = 1'b0;
        w_b     = 1'b0;
        w_cmp   = 1'b0;
        w_shamt = r_s1.b[SHW-1:0];
        w_sum   = W1'(r_s1.a) + W1'(r_s1.b) + W1'(r_s1.c_in);
        w_diff  = W1'(r_s1.a) - W1'(r_s1.b) - W1'(r_s1.b_in);
        case (r_s1.op)
            OP_PASS: begin
                w_res = r_s1.a;
                w_c   = r_s1.c_in;
            end
            OP_ADD: begin
                w_c = w_sum[WIDTH];
`ifdef SYNC_ALU_SAT_EN
                w_res = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
`else
                w_res = w_sum[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                w_b = w_diff[WIDTH];
`ifdef SYNC_ALU_SAT_EN
                w_res = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
`else
                w_res = w_diff[WIDTH-1:0];
`endif
            end
            OP_GT:   w_cmp = (r_s1.a > r_s1.b);
            OP_LT:   w_cmp = (r_s1.a < r_s1.b);
            OP_EQ:   w_cmp = (r_s1.a == r_s1.b);
            OP_SHR:  w_res = r_s1.a >> w_shamt;
            OP_SHL:  w_res = r_s1.a << w_shamt;
            default: w_res = '0;
        endcase
    end

    // Result stage: outputs only change when S2 loads a new beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            result      <= '0;
            c_out       <= 1'b0;
            b_out       <= 1'b0;
            compare_out <= 2'b00;
        end else if (w_adv2) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                result      <= w_res;
                c_out       <= w_c;
                b_out       <= w_b;
                compare_out <= {1'b0, w_cmp};
            end
        end
    end

endmodule

// File: tb/tb_sync_alu_pipe.sv
// Scoreboard bench for sync_alu_pipe: driver pushes expected beats, a
// negedge monitor pops and compares on every output handshake.
module tb_sync_alu_pipe;
    localparam int unsigned W   = 8;
    localparam int unsigned SHW = $clog2(W);

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         bo;
        logic [1:0]   cmp;
        int           acc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         b_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         c_out;
    logic         b_out;
    logic [1:0]   compare_out;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    bit   chk_lat = 0;

    sync_alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .c_in(c_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .c_out(c_out), .b_out(b_out), .compare_out(compare_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input longint act, input longint req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic bo, input logic [1:0] cm);
        exp_t e;
        e.res = r; e.c = c; e.bo = bo; e.cmp = cm; e.acc = 0;
        return e;
    endfunction

    // Reference model in plain integer arithmetic
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic bi);
        longint m  = longint'(1) << W;
        longint xa = longint'(x);
        longint ya = longint'(y);
        longint s;
        int     amt = int'(ya % (longint'(1) << SHW));
        exp_t   e = mk('0, 1'b0, 1'b0, 2'b00);
        case (o)
            3'd0: begin e.res = x; e.c = ci; end
            3'd1: begin
                s = xa + ya + longint'(ci);
                e.c = (s >= m);
                e.res = W'(s % m);
`ifdef SYNC_ALU_SAT_EN
                if (e.c) e.res = W'(m - 1);
`endif
            end
            3'd2: begin
                s = xa - ya - longint'(bi);
                e.bo = (s < 0);
                e.res = W'((s + m) % m);
`ifdef SYNC_ALU_SAT_EN
                if (e.bo) e.res = '0;
`endif
            end
            3'd3: e.cmp = (xa > ya) ? 2'b01 : 2'b00;
            3'd4: e.cmp = (xa < ya) ? 2'b01 : 2'b00;
            3'd5: e.cmp = (xa == ya) ? 2'b01 : 2'b00;
            3'd6: e.res = W'(xa / (longint'(1) << amt));
            default: e.res = W'((xa * (longint'(1) << amt)) % m);
        endcase
        return e;
    endfunction

    // Monitor: every output handshake must match the oldest expectation
    always @(negedge clk) begin
        exp_t   e;
        longint act;
        longint req;
        if (rst_n && out_valid && out_ready) begin
            act = {result, c_out, b_out, compare_out};
            if (sb.size() == 0) begin
                chk(1'b0, "unexpected_beat", act, 0);
            end else begin
                e   = sb.pop_front();
                req = {e.res, e.c, e.bo, e.cmp};
                chk(act == req, "beat_{res,c,b,cmp}", act, req);
                if (chk_lat) chk(cyc - e.acc == 2, "latency", cyc - e.acc, 2);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic bi, input exp_t e);
        bit done = 0;
        in_valid = 1'b1; op = o; a = x; b = y; c_in = ci; b_in = bi;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.acc = cyc;
                sb.push_back(e);
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            chk(1'b0, "send_timeout", 0, 1);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_rand();
        logic [2:0]   o  = 3'($urandom_range(0, 7));
        logic [W-1:0] x  = W'($urandom);
        logic [W-1:0] y  = W'($urandom);
        logic         ci = 1'($urandom_range(0, 1));
        logic         bi = 1'($urandom_range(0, 1));
        send(o, x, y, ci, bi, model(o, x, y, ci, bi));
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk); #2;
            t++;
        end
        chk(sb.size() == 0, "drain", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t e1, e2, e3;
        int   stale;
        bit   rdone;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0; c_in = 1'b0; b_in = 1'b0;

        @(negedge clk);
        chk({out_valid, result, c_out, b_out, compare_out} == '0, "reset_outputs",
            {out_valid, result, c_out, b_out, compare_out}, 0);
        chk(in_ready == 1'b1, "reset_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic cases
`ifdef SYNC_ALU_SAT_EN
        send(3'd1, 8'hF0, 8'h20, 1'b1, 1'b0, mk(8'hFF, 1'b1, 1'b0, 2'b00));
        send(3'd2, 8'h05, 8'h07, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b1, 2'b00));
`else
        send(3'd1, 8'hF0, 8'h20, 1'b1, 1'b0, mk(8'h11, 1'b1, 1'b0, 2'b00));
        send(3'd2, 8'h05, 8'h07, 1'b0, 1'b0, mk(8'hFE, 1'b0, 1'b1, 2'b00));
`endif
        send(3'd2, 8'h07, 8'h05, 1'b0, 1'b0, mk(8'h02, 1'b0, 1'b0, 2'b00));
        send(3'd1, 8'h12, 8'h34, 1'b1, 1'b1, mk(8'h47, 1'b0, 1'b0, 2'b00));
        send(3'd7, 8'h81, 8'h03, 1'b0, 1'b0, mk(8'h08, 1'b0, 1'b0, 2'b00));
        send(3'd6, 8'h81, 8'h0B, 1'b0, 1'b0, mk(8'h10, 1'b0, 1'b0, 2'b00));
        send(3'd3, 8'h09, 8'h03, 1'b1, 1'b1, mk(8'h00, 1'b0, 1'b0, 2'b01));
        send(3'd3, 8'h03, 8'h09, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0, 2'b00));
        send(3'd4, 8'h03, 8'h09, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0, 2'b01));
        send(3'd5, 8'h55, 8'h55, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0, 2'b01));
        send(3'd5, 8'h55, 8'h56, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0, 2'b00));
        send(3'd0, 8'h3C, 8'h00, 1'b1, 1'b1, mk(8'h3C, 1'b1, 1'b0, 2'b00));
        in_valid = 1'b0;
        drain();

        // Streaming at full rate with latency checking
        chk_lat = 1'b1;
        for (int i = 0; i < 16; i++) send_rand();
        in_valid = 1'b0;
        drain();
        chk_lat = 1'b0;

        // Back-pressure: two beats fill the pipe, the third must wait
        out_ready = 1'b0;
        e1 = mk(8'h03, 1'b0, 1'b0, 2'b00);
        e2 = mk(8'h0F, 1'b0, 1'b0, 2'b00);
        e3 = mk(8'h04, 1'b0, 1'b0, 2'b00);
        send(3'd1, 8'h01, 8'h02, 1'b0, 1'b0, e1);
        send(3'd2, 8'h10, 8'h01, 1'b0, 1'b0, e2);
        in_valid = 1'b1; op = 3'd7; a = 8'h01; b = 8'h02; c_in = 1'b0; b_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk(in_ready == 1'b0, "stall_in_ready", in_ready, 0);
            chk(out_valid && result == 8'h03, "stall_hold", {out_valid, result}, {1'b1, 8'h03});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk(in_ready == 1'b1, "release_in_ready", in_ready, 1);
        chk(out_valid == 1'b1, "release_beat1", out_valid, 1);
        e3.acc = cyc;
        sb.push_back(e3);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk(out_valid == 1'b1, "release_beat2", out_valid, 1);
        @(negedge clk);
        chk(out_valid == 1'b1, "release_beat3", out_valid, 1);
        @(posedge clk); #1;
        drain();

        // Random sink stalls against random traffic
        rdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) send_rand();
                in_valid = 1'b0;
                rdone = 1'b1;
            end
            begin
                for (int t = 0; t < 5000 && !rdone; t++) begin
                    @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Asynchronous reset with two beats in flight
        send(3'd1, 8'h11, 8'h22, 1'b0, 1'b0, mk(8'h33, 1'b0, 1'b0, 2'b00));
        send(3'd0, 8'h5A, 8'h00, 1'b1, 1'b0, mk(8'h5A, 1'b1, 1'b0, 2'b00));
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk({out_valid, result, c_out, b_out, compare_out} == '0, "async_reset_outputs",
            {out_valid, result, c_out, b_out, compare_out}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk(in_ready == 1'b1, "post_reset_in_ready", in_ready, 1);
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk(stale == 0, "post_reset_stale", stale, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
